// File: rtl/nios2_debug_cmd_sysclk_bridge.sv
// System-clock side of the Nios II JTAG debug slave: synchronises TCK-domain update strobes,
// queues DR updates as commands and issues per-IR take_action pulses. Option: DBG_CMD_PARITY_EN.
module nios2_debug_cmd_sysclk_bridge #(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACTION_BIT  = 34
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      vs_udr,
  input  logic                      vs_uir,
  input  logic [IR_W-1:0]           ir_in,
  input  logic [SR_W-1:0]           sr,
`ifdef DBG_CMD_PARITY_EN
  input  logic                      sr_par,
  output logic                      parity_err,
`endif
  input  logic                      cmd_ready,
  input  logic                      ovf_clr,
  output logic                      cmd_valid,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [SR_W-1:0]           jdo,
  output logic [(2**IR_W)-1:0]      take_action,
  output logic [(2**IR_W)-1:0]      take_no_action,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NCMD = 2**IR_W;

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_prev;
  logic                   r_uir_prev;
  logic                   r_udr_ev;
  logic                   r_uir_ev;
  logic [IR_W-1:0]        r_ir_q;

  logic [IR_W-1:0]        r_mem_ir [DEPTH];
  logic [SR_W-1:0]        r_mem_sr [DEPTH];
  logic [AW:0]            r_wr_cnt;
  logic [AW:0]            r_rd_cnt;

  logic [SR_W-1:0]        r_jdo;
  logic [NCMD-1:0]        r_take_action;
  logic [NCMD-1:0]        r_take_no_action;
  logic                   r_overflow;

  logic [AW:0]            w_level;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_par_ok;
  logic                   w_push_req;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_ovf_set;
  logic [AW-1:0]          w_wr_ptr;
  logic [AW-1:0]          w_rd_ptr;
  logic [IR_W-1:0]        w_head_ir;
  logic [SR_W-1:0]        w_head_sr;

  // Edge pulses are registered so the push sees a full cycle of settled IR/SR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_prev <= 1'b0;
      r_uir_prev <= 1'b0;
      r_udr_ev   <= 1'b0;
      r_uir_ev   <= 1'b0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
      r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
      r_udr_ev   <= r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;
      r_uir_ev   <= r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_q <= '0;
    end else if (r_uir_ev) begin
      r_ir_q <= ir_in;
    end
  end

`ifdef DBG_CMD_PARITY_EN
  logic r_parity_err;

  assign w_par_ok = ~(^{sr, sr_par});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity_err <= 1'b0;
    end else if (r_udr_ev && !w_par_ok) begin
      r_parity_err <= 1'b1;
    end else if (ovf_clr) begin
      r_parity_err <= 1'b0;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_level    = r_wr_cnt - r_rd_cnt;
  assign w_empty    = (w_level == '0);
  assign w_full     = (w_level == (AW+1)'(DEPTH));
  assign w_wr_ptr   = r_wr_cnt[AW-1:0];
  assign w_rd_ptr   = r_rd_cnt[AW-1:0];
  assign w_head_ir  = r_mem_ir[w_rd_ptr];
  assign w_head_sr  = r_mem_sr[w_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop      = ~w_empty & cmd_ready;
  assign w_push_req = r_udr_ev & w_par_ok;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_ir[i] <= '0;
        r_mem_sr[i] <= '0;
      end
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem_ir[w_wr_ptr] <= r_ir_q;
        r_mem_sr[w_wr_ptr] <= sr;
        r_wr_cnt           <= r_wr_cnt + 1'b1;
      end
      if (w_pop) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jdo            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
    end else begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_pop) begin
        r_jdo <= w_head_sr;
        if (w_head_sr[ACTION_BIT]) begin
          r_take_action[w_head_ir] <= 1'b1;
        end else begin
          r_take_no_action[w_head_ir] <= 1'b1;
        end
      end
    end
  end

  // Set beats clear so an overflow coinciding with ovf_clr is never missed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign cmd_valid      = ~w_empty;
  assign cmd_ir         = w_head_ir;
  assign level          = w_level;
  assign jdo            = r_jdo;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_nios2_debug_cmd_sysclk_bridge.sv
// Directed bench for nios2_debug_cmd_sysclk_bridge with default parameters.
module tb_nios2_debug_cmd_sysclk_bridge;

  logic        clk;
  logic        reset_n;
  logic        vs_udr;
  logic        vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready;
  logic        ovf_clr;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic [2:0]  level;
  logic        overflow;
`ifdef DBG_CMD_PARITY_EN
  logic        sr_par;
  logic        parity_err;
`endif

  int errors = 0;
  int checks = 0;

  nios2_debug_cmd_sysclk_bridge dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
`ifdef DBG_CMD_PARITY_EN
    .sr_par         (sr_par),
    .parity_err     (parity_err),
`endif
    .cmd_ready      (cmd_ready),
    .ovf_clr        (ovf_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .level          (level),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] sr;
    logic [3:0]  ta;
    logic [3:0]  tna;
  } vec_t;

  vec_t        vecs [5];
  logic [37:0] p [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_sr(input logic [37:0] d);
    sr = d;
`ifdef DBG_CMD_PARITY_EN
    sr_par = ^d;
`endif
  endtask

  task automatic udr_pulse(input logic [37:0] d);
    set_sr(d);
    vs_udr = 1'b1;
    repeat (4) tick();
    vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic uir_pulse(input logic [1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (4) tick();
    vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    vecs[0] = '{ir: 2'd0, sr: 38'h04_0000_0001, ta: 4'b0001, tna: 4'b0000};
    vecs[1] = '{ir: 2'd3, sr: 38'h00_1234_5678, ta: 4'b0000, tna: 4'b1000};
    vecs[2] = '{ir: 2'd2, sr: 38'h3F_FFFF_FFFF, ta: 4'b0100, tna: 4'b0000};
    vecs[3] = '{ir: 2'd1, sr: 38'h3B_FFFF_FFFF, ta: 4'b0000, tna: 4'b0010};
    vecs[4] = '{ir: 2'd1, sr: 38'h02_0000_00AB, ta: 4'b0000, tna: 4'b0010};
    p[0] = 38'h00_0000_0011;
    p[1] = 38'h04_0000_0022;
    p[2] = 38'h00_0000_0033;
    p[3] = 38'h04_0000_0044;
    p[4] = 38'h04_0000_0055;

    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0;
    cmd_ready = 1'b0; ovf_clr = 1'b0;
    set_sr('0);
    repeat (2) tick();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_jdo", jdo, 0);
    chk("rst_ta", take_action, 0);
    chk("rst_tna", take_no_action, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cmd_ir", cmd_ir, 0);
`ifdef DBG_CMD_PARITY_EN
    chk("rst_parity_err", parity_err, 0);
`endif
    reset_n = 1'b1;
    tick();

    // Latency and single action pulse; cmd_ready held high while empty.
    uir_pulse(2'd1);
    cmd_ready = 1'b1;
    set_sr(38'h4_0000_00AB);
    vs_udr = 1'b1;
    repeat (3) tick();
    chk("lat_not_yet", cmd_valid, 0);
    tick();
    chk("lat_valid", cmd_valid, 1);
    chk("lat_level", level, 1);
    chk("lat_cmd_ir", cmd_ir, 1);
    tick();
    chk("lat_ta", take_action, 4'b0010);
    chk("lat_tna", take_no_action, 4'b0000);
    chk("lat_jdo", jdo, 38'h4_0000_00AB);
    tick();
    chk("lat_ta_end", take_action, 4'b0000);
    chk("lat_level_end", level, 0);
    vs_udr = 1'b0;
    repeat (3) tick();
    cmd_ready = 1'b0;

    // Table-driven single commands.
    for (int i = 0; i < 5; i++) begin
      uir_pulse(vecs[i].ir);
      udr_pulse(vecs[i].sr);
      chk("vec_valid", cmd_valid, 1);
      chk("vec_cmd_ir", cmd_ir, vecs[i].ir);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("vec_ta", take_action, vecs[i].ta);
      chk("vec_tna", take_no_action, vecs[i].tna);
      chk("vec_jdo", jdo, vecs[i].sr);
      tick();
      chk("vec_ta_off", take_action, 0);
      chk("vec_tna_off", take_no_action, 0);
      chk("vec_level", level, 0);
    end

    // Overflow: five pushes into four entries, drain in order.
    uir_pulse(2'd2);
    for (int i = 0; i < 5; i++) udr_pulse(p[i]);
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cmd_ir", cmd_ir, 2);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_jdo", jdo, p[i]);
      chk("drain_ta", take_action, p[i][34] ? 4'b0100 : 4'b0000);
      chk("drain_tna", take_no_action, p[i][34] ? 4'b0000 : 4'b0100);
    end
    cmd_ready = 1'b0;
    tick();
    chk("drain_level", level, 0);
    chk("drain_valid", cmd_valid, 0);
    chk("drain_lost5", jdo, p[3]);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Full FIFO with a push and a pop in the same cycle.
    for (int i = 0; i < 4; i++) udr_pulse(p[i]);
    chk("full_level", level, 4);
    set_sr(p[4]);
    vs_udr = 1'b1;
    repeat (3) tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("pp_level", level, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_jdo", jdo, p[0]);
    vs_udr = 1'b0;
    repeat (3) tick();
    cmd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("pp_drain_jdo", jdo, p[i]);
    end
    cmd_ready = 1'b0;
    tick();
    chk("pp_drain_level", level, 0);
    chk("pp_ovf_end", overflow, 0);

    // IR and DR updates landing in the same cycle.
    uir_pulse(2'd0);
    ir_in = 2'd3;
    set_sr(38'h0_0000_0AAA);
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    repeat (4) tick();
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    repeat (3) tick();
    chk("same_cmd_ir", cmd_ir, 0);
    chk("same_level", level, 1);
    udr_pulse(38'h0_0000_0BBB);
    chk("same_level2", level, 2);
    cmd_ready = 1'b1;
    tick();
    chk("same_tna0", take_no_action, 4'b0001);
    chk("same_head_ir", cmd_ir, 3);
    tick();
    chk("same_tna3", take_no_action, 4'b1000);
    chk("same_jdo", jdo, 38'h0_0000_0BBB);
    cmd_ready = 1'b0;
    tick();

`ifdef DBG_CMD_PARITY_EN
    sr     = 38'h0_0000_0001;
    sr_par = 1'b0;
    vs_udr = 1'b1;
    repeat (4) tick();
    vs_udr = 1'b0;
    repeat (3) tick();
    chk("par_level", level, 0);
    chk("par_err", parity_err, 1);
    chk("par_ovf", overflow, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("par_clr", parity_err, 0);
`endif

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) udr_pulse(p[i]);
    chk("mid_level", level, 3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_jdo", jdo, 0);
    chk("mid_rst_ta", take_action, 0);
    chk("mid_rst_tna", take_no_action, 0);
    #3;
    reset_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_valid", cmd_valid, 0);
    udr_pulse(p[1]);
    chk("post_rst_push", cmd_valid, 1);
    chk("post_rst_level", level, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
